// File: rtl/multicycle_controller.sv
// Control FSM for a multicycle MIPS-style datapath: sequences fetch, decode and
// per-instruction execute/writeback steps, stalling on memory completion.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t state_q;
  state_t state_d;
  state_t dec_state;

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; op is consulted only here.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // While reset is held the outputs show the FETCH decode without any loads.
  assign dec_state = rst ? S_FETCH : state_q;

  // Moore-style output decode, plus mem_ready/zero qualified enables.
  always_comb begin
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    pc_en      = 1'b0;
    case (dec_state)
      S_FETCH: begin
        alu_src_b = 2'b01;
        ir_write  = mem_ready & ~rst;
        pc_en     = mem_ready & ~rst;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        pc_en     = zero;
      end
      S_JUMP: begin
        pc_src = 2'b10;
        pc_en  = 1'b1;
      end
      default: begin
        iord = 1'b0;
      end
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed plus randomized bench for multicycle_controller, checked against an
// instruction-path reference model.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst, zero, mem_ready;
  logic [5:0] op;
  logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, pc_en;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;

  int tests = 0;
  int fails = 0;
  int mw_seen = 0;

  // Reference model: current instruction path and position along it.
  logic [5:0] m_op = 6'h3f;
  int         m_idx = 0;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
    .iord(iord), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src), .pc_en(pc_en),
    .state(state)
  );

  always #5 clk = ~clk;

  // Sequence of states each instruction visits, starting at FETCH.
  function automatic int path_len(logic [5:0] o);
    case (o)
      6'b100011: return 5;
      6'b101011, 6'b000000, 6'b001000: return 4;
      6'b000100, 6'b000010: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int path_at(logic [5:0] o, int i);
    int p [5];
    p = '{0, 1, 0, 0, 0};
    case (o)
      6'b100011: p = '{0, 1, 2, 3, 4};
      6'b101011: p = '{0, 1, 2, 5, 0};
      6'b000000: p = '{0, 1, 6, 7, 0};
      6'b001000: p = '{0, 1, 9, 10, 0};
      6'b000100: p = '{0, 1, 8, 0, 0};
      6'b000010: p = '{0, 1, 11, 0, 0};
      default:   p = '{0, 1, 0, 0, 0};
    endcase
    return p[i];
  endfunction

  // Expected {iord,mem_write,ir_write,reg_dst,mem_to_reg,reg_write,alu_src_a,alu_src_b,alu_op,pc_src,pc_en}.
  function automatic logic [13:0] exp_ctrl(int s, logic rdy, logic z, logic r);
    logic io, mw, irw, rd, m2r, rw, asa, pce;
    logic [1:0] asb, aop, pcs;
    {io, mw, irw, rd, m2r, rw, asa, pce} = 8'h00;
    {asb, aop, pcs} = 6'b000000;
    if (r) s = 0;
    case (s)
      0: begin asb = 2'b01; irw = rdy & ~r; pce = rdy & ~r; end
      1: asb = 2'b11;
      2, 9: begin asa = 1'b1; asb = 2'b10; end
      3: io = 1'b1;
      5: begin io = 1'b1; mw = 1'b1; end
      4: begin m2r = 1'b1; rw = 1'b1; end
      6: begin asa = 1'b1; aop = 2'b10; end
      7: begin rd = 1'b1; rw = 1'b1; end
      10: rw = 1'b1;
      8: begin asa = 1'b1; aop = 2'b01; pcs = 2'b01; pce = z; end
      11: begin pcs = 2'b10; pce = 1'b1; end
      default: io = 1'b0;
    endcase
    return {io, mw, irw, rd, m2r, rw, asa, asb, aop, pcs, pce};
  endfunction

  function automatic int m_state();
    return path_at(m_op, m_idx);
  endfunction

  // One clock: check outputs mid-cycle, then advance the model at the edge.
  task automatic tick();
    logic [13:0] got, exp;
    int cur;
    @(negedge clk);
    cur = m_state();
    exp = exp_ctrl(cur, mem_ready, zero, rst);
    got = {iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
           alu_src_b, alu_op, pc_src, pc_en};
    if (mem_write === 1'b1) mw_seen++;
    tests++;
    assert (state === 4'(cur)) else begin
      fails++;
      $error("FAIL state: got %0d exp %0d", state, cur);
    end
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL ctrl(state %0d rdy %0b z %0b rst %0b): got %b exp %b", cur, mem_ready, zero, rst, got, exp);
    end
    @(posedge clk);
    if (rst) begin
      m_idx = 0;
    end else if ((cur == 0 || cur == 3 || cur == 5) && !mem_ready) begin
      m_idx = m_idx;
    end else begin
      if (m_idx == 1) m_op = op;
      m_idx++;
      if (m_idx >= path_len(m_op)) m_idx = 0;
    end
    #1;
  endtask

  task automatic run(logic [5:0] o, int n);
    op = o;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic [5:0] ops [6];
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
    rst = 1'b1; op = 6'b100011; zero = 1'b0; mem_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    run(6'b100011, 5);                      // lw: 0,1,2,3,4

    op = 6'b101011;
    tick(); tick(); tick();                 // sw: FETCH, DECODE, MEMADR
    mw_seen = 0;
    mem_ready = 1'b0;
    tick(); tick(); tick();
    mem_ready = 1'b1;
    tick();
    tests++;
    assert (mw_seen === 4) else begin
      fails++;
      $error("FAIL sw_mem_write_cycles: got %0d exp 4", mw_seen);
    end
    tick();                                 // back in FETCH

    zero = 1'b1; run(6'b000100, 3);
    zero = 1'b0; run(6'b000100, 3);
    run(6'b000000, 4);
    run(6'b001000, 4);
    run(6'b111111, 2);
    run(6'b000010, 3);

    op = 6'b100011;
    tick(); tick(); tick();                 // now in MEMRD
    mem_ready = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; mem_ready = 1'b1;
    tests++;
    assert (state === 4'd0) else begin
      fails++;
      $error("FAIL rst_in_memrd: got %0d exp 0", state);
    end
    tick();

    for (int i = 0; i < 600; i++) begin
      if (m_state() == 0 && $urandom_range(0, 1) == 0) begin
        if ($urandom_range(0, 7) == 0) op = 6'($urandom);
        else op = ops[$urandom_range(0, 5)];
      end
      mem_ready = ($urandom_range(0, 3) != 0);
      zero = 1'($urandom);
      rst = ($urandom_range(0, 49) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 op  input  6  instruction opcode field from the instruction register.
REQ-005 zero  input  1  ALU zero flag.
REQ-006 mem_ready  input  1  memory completion; high in the cycle the access completes.
REQ-007 iord  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-008 mem_write  output  1  memory write strobe.
REQ-009 ir_write  output  1  instruction register load.
REQ-010 reg_dst  output  1  destination register select: 1 = rd, 0 = rt.
REQ-011 mem_to_reg  output  1  writeback source select: 1 = data register, 0 = ALUOut.
REQ-012 reg_write  output  1  register file write enable.
REQ-013 alu_src_a  output  1  ALU A source: 0 = PC, 1 = register A.
REQ-014 alu_src_b  output  2  ALU B source: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = shifted immediate.
REQ-015 alu_op  output  2  ALU decoder class: 00 = add, 01 = subtract, 10 = funct-decoded.
REQ-016 pc_src  output  2  next-PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-017 pc_en  output  1  PC register load enable.
REQ-018 state  output  4  current state code, for debug.

Function
REQ-019 State codes SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
REQ-020 Opcodes SHALL be: R-type=000000, lw=100011, sw=101011, beq=000100, addi=001000, j=000010.
REQ-021 Transitions SHALL be:
- FETCH -> DECODE if mem_ready=1, else stay in FETCH.
- DECODE -> MEMADR for lw or sw; EXEC for R-type; BRANCH for beq; ADDIEX for addi; JUMP for j; FETCH for any other opcode.
- MEMADR -> MEMRD for lw; MEMWR for sw.
- MEMRD -> MEMWB if mem_ready=1, else stay in MEMRD.
- MEMWR -> FETCH if mem_ready=1, else stay in MEMWR.
- MEMWB, ALUWB, ADDIWB, BRANCH, JUMP -> FETCH.
- EXEC -> ALUWB; ADDIEX -> ADDIWB.
- Codes 12-15 -> FETCH.
REQ-022 Every output not listed for a state in REQ-023 SHALL be 0 in that state.
REQ-023 Per-state outputs:
- FETCH: iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00; ir_write=mem_ready; pc_en=mem_ready.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00.
- MEMADR, ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00.
- MEMRD: iord=1.
- MEMWR: iord=1, mem_write=1.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10.
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_en=zero.
- JUMP: pc_src=10, pc_en=1.
REQ-024 Outputs SHALL be combinational from state, mem_ready and zero only; op SHALL affect only the next state.
REQ-025 mem_write SHALL stay asserted for every MEMWR cycle until mem_ready completes the access.
REQ-026 Minimum cycle counts with mem_ready held at 1 SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
REQ-027 Each mem_ready-low cycle in FETCH, MEMRD or MEMWR SHALL add exactly one cycle of latency.
REQ-028 An unknown opcode SHALL pass through DECODE, return to FETCH, and cause no reg_write or mem_write.

Reset
REQ-029 rst=1 at a rising edge SHALL force state to FETCH, regardless of current state or pending memory access.
REQ-030 While rst=1, all outputs SHALL follow the FETCH decode, and ir_write and pc_en SHALL be forced to 0.

Verification
REQ-031 The bench SHALL cover at least these scenarios:
- rst for 2 cycles, op=100011, mem_ready=1 -> state sequence 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4.
- sw with mem_ready low for 3 cycles in MEMWR -> mem_write=1 for 4 consecutive cycles; state stays 5, then goes to 0.
- beq with zero=1, then beq with zero=0 -> pc_en=1 with pc_src=01 in BRANCH for the first; pc_en=0 in BRANCH for the second.
- R-type, then addi -> alu_op=10 in EXEC; reg_dst=1 in ALUWB; reg_dst=0 in ADDIWB.
- op=111111 -> sequence 0,1,0 with no reg_write or mem_write.
- rst asserted while in MEMRD -> state=0 on the next edge; ir_write=0 and pc_en=0 while rst is high.
